// File: rtl/sonata_pkg.sv
// Shared Sonata definitions: inout pin count plus the pin-claim operation encoding,
// pin index type and claim-arbiter FSM states.
package sonata_pkg;

  localparam int INOUT_PIN_NUM = 70;

  typedef enum logic [1:0] {
    PinClaim      = 2'd0,
    PinRelease    = 2'd1,
    PinReleaseAll = 2'd2,
    PinOpRsvd     = 2'd3
  } pin_claim_op_e;

  localparam int PIN_IDX_W = $clog2(INOUT_PIN_NUM);

  typedef logic [PIN_IDX_W-1:0] pin_idx_t;

  typedef enum logic [1:0] {
    ClaimIdle = 2'd0,
    ClaimScan = 2'd1,
    ClaimResp = 2'd2
  } pin_claim_state_e;

endpackage

// File: rtl/pin_claim_rr_arb.sv
// Round-robin arbiter: searches from last-granted+1 and moves its pointer only
// when a grant is actually taken (advance high).
module pin_claim_rr_arb #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] cand;
  logic             found;

  // NOTE: every comb output gets a default before the search loop, so no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IDX_W'((int'(last_q) + i) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Pointer starts at N-1 so requester 0 has priority out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IDX_W'(N - 1);
    end else if (advance && found) begin
      last_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/sonata_pin_claim_arb.sv
// Pin ownership arbiter: serialises claim/release requests from several ports and
// keeps a per-pin {valid, owner} table that gates pinmux output enables.
module sonata_pin_claim_arb
  import sonata_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int PIN_NUM   = INOUT_PIN_NUM,
  localparam int REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*2-1:0]           req_op_i,
  input  logic [NUM_REQ*PIN_IDX_W-1:0]   req_pin_i,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  output logic                           rsp_ok_o,
  output logic [PIN_NUM-1:0]             owner_valid_o,
  output logic [PIN_NUM*REQ_IDX_W-1:0]   owner_id_o,
  output logic                           busy_o
);

  pin_claim_state_e     state_q, state_d;
  logic [NUM_REQ-1:0]   gnt;
  logic [REQ_IDX_W-1:0] gnt_idx, lat_id;
  logic [REQ_IDX_W-1:0] owner_id [PIN_NUM];
  logic                 idle, accept, scan_last, rsp_ok_q;
  logic                 in_range, own_v, own_me, ok_c;
  pin_claim_op_e        g_op;
  pin_idx_t             g_pin, scan_cnt;

  pin_claim_rr_arb #(.N(NUM_REQ)) u_arb (
    .clk     (clk_i),
    .rst     (rst_i),
    .req     (req_valid_i),
    .advance (idle),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign idle        = (state_q == ClaimIdle);
  assign accept      = idle && (|gnt);
  assign scan_last   = (scan_cnt == PIN_IDX_W'(PIN_NUM - 1));
  assign req_ready_o = (idle && !rst_i) ? gnt : '0;
  assign busy_o      = !idle;
  assign rsp_ok_o    = (state_q == ClaimResp) && rsp_ok_q;

  // Outcome of the granted request, judged against the table as registered before this edge.
  always_comb begin
    g_op     = pin_claim_op_e'(req_op_i[2*gnt_idx +: 2]);
    g_pin    = req_pin_i[PIN_IDX_W*gnt_idx +: PIN_IDX_W];
    in_range = (32'(g_pin) < PIN_NUM);
    own_v    = in_range && owner_valid_o[g_pin];
    own_me   = own_v && (owner_id[g_pin] == gnt_idx);
    ok_c     = 1'b0;
    unique case (g_op)
      PinClaim:      ok_c = in_range && (!own_v || own_me);
      PinRelease:    ok_c = own_me;
      PinReleaseAll: ok_c = 1'b1;
      default:       ok_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ClaimIdle: if (accept) state_d = (g_op == PinReleaseAll) ? ClaimScan : ClaimResp;
      ClaimScan: if (scan_last) state_d = ClaimResp;
      ClaimResp: state_d = ClaimIdle;
      default:   state_d = ClaimIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ClaimIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the table is a flop array, not RAM; it must clear on reset so no pin starts owned.
      owner_valid_o <= '0;
      for (int i = 0; i < PIN_NUM; i++) owner_id[i] <= '0;
      lat_id   <= '0;
      rsp_ok_q <= 1'b0;
      scan_cnt <= '0;
    end else begin
      unique case (state_q)
        ClaimIdle: begin
          if (accept) begin
            lat_id   <= gnt_idx;
            rsp_ok_q <= ok_c;
            if (ok_c && g_op == PinClaim) begin
              owner_valid_o[g_pin] <= 1'b1;
              owner_id[g_pin]      <= gnt_idx;
            end else if (ok_c && g_op == PinRelease) begin
              owner_valid_o[g_pin] <= 1'b0;
              owner_id[g_pin]      <= '0;
            end
          end
        end
        ClaimScan: begin
          if (owner_valid_o[scan_cnt] && owner_id[scan_cnt] == lat_id) begin
            owner_valid_o[scan_cnt] <= 1'b0;
            owner_id[scan_cnt]      <= '0;
          end
          scan_cnt <= scan_last ? '0 : scan_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    owner_id_o = '0;
    for (int i = 0; i < PIN_NUM; i++) owner_id_o[i*REQ_IDX_W +: REQ_IDX_W] = owner_id[i];
  end

  always_comb begin
    rsp_valid_o = '0;
    if (state_q == ClaimResp) rsp_valid_o[lat_id] = 1'b1;
  end

endmodule
